// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache miss reads and a dcache writeback FIFO onto a single memory port.
// Stores win when the buffer is nearly full or a read would bypass a pending writeback of the same block.
module mem_arbiter #(
    parameter int WB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int BLOCK_W  = 64,
    parameter int TAG_W    = 4,
    parameter int OFFSET_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    // Address packets are {valid, address}; the valid bit sits at index ADDR_W.
    input  logic [ADDR_W:0]    icache_req_addr,
    input  logic [ADDR_W:0]    dcache_req_addr,
    input  logic               dcache_wb_valid,
    input  logic [ADDR_W:0]    dcache_wb_addr,
    input  logic [BLOCK_W-1:0] dcache_wb_data,
    input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
    output logic               icache_req_accepted,
    output logic               dcache_req_accepted,
    output logic [TAG_W-1:0]   current_req_tag,
    output logic [1:0]         proc2mem_command,
    output logic [ADDR_W-1:0]  proc2mem_addr,
    output logic [BLOCK_W-1:0] proc2mem_data,
    output logic               wb_full,
    output logic               wb_overflow
);

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BLOCK_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    logic [ADDR_W-1:0]  wb_addr_mem [WB_DEPTH];
    logic [BLOCK_W-1:0] wb_data_mem [WB_DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;
    logic               last_grant_dcache;

    logic               ic_valid, dc_valid;
    logic [ADDR_W-1:0]  ic_block, dc_block;
    logic               hazard;
    logic               sel_store, sel_ic, sel_dc;
    logic               accepted, pop, push_ok;

    assign ic_valid = icache_req_addr[ADDR_W];
    assign dc_valid = dcache_req_addr[ADDR_W];
    assign ic_block = icache_req_addr[ADDR_W-1:0] & BLOCK_MASK;
    assign dc_block = dcache_req_addr[ADDR_W-1:0] & BLOCK_MASK;
    assign wb_full  = (count == CNT_W'(WB_DEPTH));

    // Only slots between head and head+count hold live writebacks.
    always_comb begin
        logic [PTR_W-1:0] rel;
        hazard = 1'b0;
        rel    = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            rel = PTR_W'(i) - head;
            if ({1'b0, rel} < count) begin
                if (ic_valid && ((wb_addr_mem[i] & BLOCK_MASK) == ic_block))
                    hazard = 1'b1;
                if (dc_valid && ((wb_addr_mem[i] & BLOCK_MASK) == dc_block))
                    hazard = 1'b1;
            end
        end
    end

    always_comb begin
        sel_store = 1'b0;
        sel_ic    = 1'b0;
        sel_dc    = 1'b0;
        if (reset) begin
            sel_store = 1'b0;
        end else if (count >= CNT_W'(WB_DEPTH - 1)) begin
            sel_store = 1'b1;
        end else if (hazard) begin
            sel_store = 1'b1;
        end else if (ic_valid && dc_valid) begin
            sel_ic = last_grant_dcache;
            sel_dc = !last_grant_dcache;
        end else if (ic_valid) begin
            sel_ic = 1'b1;
        end else if (dc_valid) begin
            sel_dc = 1'b1;
        end else if (count != '0) begin
            sel_store = 1'b1;
        end
    end

    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (sel_store) begin
            proc2mem_command = MEM_STORE;
            proc2mem_addr    = wb_addr_mem[head] & BLOCK_MASK;
            proc2mem_data    = wb_data_mem[head];
        end else if (sel_ic) begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = ic_block;
        end else if (sel_dc) begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = dc_block;
        end
    end

    assign accepted            = !reset && (mem2proc_transaction_tag != '0);
    assign icache_req_accepted = accepted && sel_ic;
    assign dcache_req_accepted = accepted && sel_dc;
    assign current_req_tag     = (accepted && (sel_ic || sel_dc)) ? mem2proc_transaction_tag : '0;
    assign pop                 = accepted && sel_store;
    assign push_ok             = !reset && dcache_wb_valid && (!wb_full || pop);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            wb_addr_mem[tail] <= dcache_wb_addr[ADDR_W-1:0];
            wb_data_mem[tail] <= dcache_wb_data;
        end
    end

    // A full-buffer push only survives when the head drains in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            last_grant_dcache <= 1'b1;
            wb_overflow       <= 1'b0;
        end else begin
            if (push_ok)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (dcache_wb_valid && wb_full && !pop)
                wb_overflow <= 1'b1;
            if (accepted && (sel_ic || sel_dc))
                last_grant_dcache <= sel_dc;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a queue-based model of the arbitration rules.
module tb_mem_arbiter;

    localparam int WB_DEPTH = 4;
    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wbEntry_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [32:0] icache_req_addr, dcache_req_addr, dcache_wb_addr;
    logic        dcache_wb_valid;
    logic [63:0] dcache_wb_data;
    logic [3:0]  mem2proc_transaction_tag;
    logic        icache_req_accepted, dcache_req_accepted;
    logic [3:0]  current_req_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic        wb_full, wb_overflow;

    int assertCount = 0;
    int failCount   = 0;

    wbEntry_t modelQ[$];
    logic     modelLastDcache;
    logic     modelOverflow;
    logic     lastIcAccepted, lastDcAccepted;

    mem_arbiter #(.WB_DEPTH(WB_DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .icache_req_addr(icache_req_addr),
        .dcache_req_addr(dcache_req_addr),
        .dcache_wb_valid(dcache_wb_valid),
        .dcache_wb_addr(dcache_wb_addr),
        .dcache_wb_data(dcache_wb_data),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .icache_req_accepted(icache_req_accepted),
        .dcache_req_accepted(dcache_req_accepted),
        .current_req_tag(current_req_tag),
        .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .wb_full(wb_full),
        .wb_overflow(wb_overflow)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] blockOf(input logic [31:0] a);
        return a & ~32'h7;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model at the edge.
    task automatic applyStimulus(input logic rst, input logic icV, input logic [31:0] icA,
                                 input logic dcV, input logic [31:0] dcA,
                                 input logic wbV, input logic [31:0] wbA, input logic [63:0] wbD,
                                 input logic [3:0] tag);
        logic        hazard, store, grantIc, grantDc, acc, wasFull;
        logic [1:0]  expCmd;
        logic [31:0] expAddr;
        logic [63:0] expData;
        wbEntry_t    e;
        reset = rst;
        icache_req_addr = {icV, icA};
        dcache_req_addr = {dcV, dcA};
        dcache_wb_valid = wbV;
        dcache_wb_addr  = {wbV, wbA};
        dcache_wb_data  = wbD;
        mem2proc_transaction_tag = tag;

        hazard = 1'b0;
        foreach (modelQ[j]) begin
            if (icV && blockOf(modelQ[j].addr) == blockOf(icA)) hazard = 1'b1;
            if (dcV && blockOf(modelQ[j].addr) == blockOf(dcA)) hazard = 1'b1;
        end
        store = 1'b0; grantIc = 1'b0; grantDc = 1'b0;
        if (!rst) begin
            if (modelQ.size() >= WB_DEPTH - 1 || hazard) store = 1'b1;
            else if (icV && dcV) begin grantIc = modelLastDcache; grantDc = !modelLastDcache; end
            else if (icV) grantIc = 1'b1;
            else if (dcV) grantDc = 1'b1;
            else if (modelQ.size() > 0) store = 1'b1;
        end
        expCmd = MEM_NONE; expAddr = '0; expData = '0;
        if (store) begin
            expCmd = MEM_STORE; expAddr = blockOf(modelQ[0].addr); expData = modelQ[0].data;
        end else if (grantIc) begin
            expCmd = MEM_LOAD; expAddr = blockOf(icA);
        end else if (grantDc) begin
            expCmd = MEM_LOAD; expAddr = blockOf(dcA);
        end
        acc = !rst && tag != 0;
        wasFull = (modelQ.size() == WB_DEPTH);

        #3;
        checkOutput("command",  64'(proc2mem_command), 64'(expCmd));
        checkOutput("addr",     64'(proc2mem_addr), 64'(expAddr));
        checkOutput("data",     proc2mem_data, expData);
        checkOutput("ic_acc",   64'(icache_req_accepted), 64'(acc && grantIc));
        checkOutput("dc_acc",   64'(dcache_req_accepted), 64'(acc && grantDc));
        checkOutput("req_tag",  64'(current_req_tag), (acc && (grantIc || grantDc)) ? 64'(tag) : 64'd0);
        checkOutput("wb_full",  64'(wb_full), 64'(wasFull));
        checkOutput("overflow", 64'(wb_overflow), 64'(modelOverflow));
        lastIcAccepted = acc && grantIc;
        lastDcAccepted = acc && grantDc;

        @(posedge clock);
        if (rst) begin
            modelQ.delete();
            modelLastDcache = 1'b1;
            modelOverflow   = 1'b0;
        end else begin
            if (store && acc) void'(modelQ.pop_front());
            if (wbV) begin
                if (!wasFull || (store && acc)) begin
                    e.addr = wbA; e.data = wbD;
                    modelQ.push_back(e);
                end else begin
                    modelOverflow = 1'b1;
                end
            end
            if (acc && (grantIc || grantDc)) modelLastDcache = grantDc;
        end
        #1;
    endtask

    function automatic logic [31:0] randAddr();
        return (32'($urandom_range(1, 4)) << 12) | 32'($urandom_range(0, 15));
    endfunction

    initial begin
        logic        icV, dcV, wbV;
        logic [31:0] icA, dcA;
        logic [3:0]  tag;
        modelLastDcache = 1'b1;
        modelOverflow   = 1'b0;
        reset = 1'b1;
        icache_req_addr = '0; dcache_req_addr = '0; dcache_wb_addr = '0;
        dcache_wb_valid = 1'b0; dcache_wb_data = '0; mem2proc_transaction_tag = '0;
        @(posedge clock); #1;

        // Reset cycle with a coincident writeback that must be ignored.
        applyStimulus(1, 0, 0, 0, 0, 1, 32'h9000, 64'hdead, 4'd1);
        // Round-robin tie: icache first, then dcache.
        applyStimulus(0, 1, 32'h1000, 1, 32'h2000, 0, 0, 0, 4'd3);
        applyStimulus(0, 1, 32'h1000, 1, 32'h2000, 0, 0, 0, 4'd3);
        // Writeback then hazarding dcache read: store first, load next.
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h3000, 64'h1234_5678_9abc_def0, 4'd0);
        applyStimulus(0, 0, 0, 1, 32'h3004, 0, 0, 0, 4'd5);
        applyStimulus(0, 0, 0, 1, 32'h3004, 0, 0, 0, 4'd5);
        // Rejected load held for three cycles, then accepted.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h4000, 0, 0, 0, 0, 0, 4'd0);
        applyStimulus(0, 1, 32'h4000, 0, 0, 0, 0, 0, 4'd2);
        // Three pushes with both reads pending, then fill, overflow, and reset.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 32'h5000, 1, 32'h6000, 1, 32'h7000 + 32'(i*8), 64'(i), 4'd0);
        applyStimulus(0, 1, 32'h5000, 1, 32'h6000, 0, 0, 0, 4'd7);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h7100, 64'haa, 4'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h7200, 64'hbb, 4'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h7300, 64'hcc, 4'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 4'd0);
        // Refill, then simultaneous accepted store and push while full.
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000 + 32'(i*8), 64'(i+10), 4'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8100, 64'hee, 4'd6);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 4'd0);

        icV = 0; dcV = 0; icA = 0; dcA = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!icV || lastIcAccepted) begin icV = ($urandom_range(0, 2) != 0); icA = randAddr(); end
            if (!dcV || lastDcAccepted) begin dcV = ($urandom_range(0, 2) != 0); dcA = randAddr(); end
            wbV = ($urandom_range(0, 4) < 2);
            tag = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 15));
            applyStimulus(($urandom_range(0, 99) == 0), icV, icA, dcV, dcA,
                          wbV, randAddr(), {$urandom, $urandom}, tag);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
